pushbutton_capture_slave: RTL and testbench

PUSHBUTTON_CAPTURE_SLAVE -- requirements
Module: pushbutton_capture_slave

---
 rtl/pushbutton_capture_slave.sv | 129 ++++++++++++
 tb/tb_pushbutton_capture_slave.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_capture_slave.sv
// Avalon-MM slave that synchronizes and debounces 4 push buttons and 16 switches,
// latches press events into a sticky EDGE register, counts presses and raises a masked irq.
module pushbutton_capture_slave #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    input  logic [3:0]  buttons_n,
    input  logic [15:0] switches,
    output logic        irq
);

    localparam int              NBITS    = 20;
    localparam logic [15:0]     CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [NBITS-1:0] IDLE_LVL = {16'h0000, 4'hF};

    logic [NBITS-1:0] r_sync_p0;
    logic [NBITS-1:0] r_sync_p1;
    logic [NBITS-1:0] r_db;
    logic [15:0]      r_cnt [NBITS];
    logic [NBITS-1:0] w_cnt_hit;
    logic [NBITS-1:0] w_db_next;
    logic [3:0]       w_press;

    logic [3:0]       r_edge;
    logic [3:0]       r_mask;
    logic [15:0]      r_press_cnt;
    logic             r_irq;
    logic [31:0]      r_rdata;
    logic             r_rdv;
    logic [3:0]       w_edge_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_unused_wdata = ^avs_writedata[31:4];

    // Stage p0/p1: two-flop synchronizer; buttons idle high, switches idle low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_p0 <= IDLE_LVL;
            r_sync_p1 <= IDLE_LVL;
            r_db      <= IDLE_LVL;
        end else begin
            r_sync_p0 <= {switches, buttons_n};
            r_sync_p1 <= r_sync_p0;
            r_db      <= w_db_next;
        end
    end

    always_comb begin
        w_cnt_hit = '0;
        for (int i = 0; i < NBITS; i++) begin
            w_cnt_hit[i] = (r_sync_p1[i] != r_db[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    // A hit implies the synchronized level differs, so toggling accepts it
    assign w_db_next = r_db ^ w_cnt_hit;
    assign w_press   = w_cnt_hit[3:0] & r_db[3:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NBITS; i++) begin
                if ((r_sync_p1[i] == r_db[i]) || w_cnt_hit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_edge_clr = (avs_write && (avs_address == 2'd1)) ? avs_writedata[3:0] : 4'h0;

    // Press set dominates a same-cycle write-1-to-clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_edge      <= '0;
            r_mask      <= '0;
            r_press_cnt <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_edge_clr) | w_press;
            if (avs_write && (avs_address == 2'd2)) begin
                r_mask <= avs_writedata[3:0];
            end
            if (|w_press) begin
                r_press_cnt <= r_press_cnt + 16'd1;
            end
            r_irq <= |(r_edge & r_mask);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (avs_address)
            2'd0:    w_rd_mux = {12'h000, r_db[19:4], ~r_db[3:0]};
            2'd1:    w_rd_mux = {28'h0, r_edge};
            2'd2:    w_rd_mux = {28'h0, r_mask};
            default: w_rd_mux = {16'h0000, r_press_cnt};
        endcase
    end

    // Stage p1: read response one cycle after the request, zero when idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdv   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdv   <= avs_read;
            r_rdata <= avs_read ? w_rd_mux : 32'h0;
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rdv;
    assign irq               = r_irq;

endmodule

// File: tb/tb_pushbutton_capture_slave.sv
// Table-driven bench for pushbutton_capture_slave with DEBOUNCE_CYCLES = 4,
// plus hand-written sequences for cycle-exact corner cases.
module tb_pushbutton_capture_slave;

    localparam int OP_HOLD = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;
    localparam int OP_RW   = 3;

    typedef struct {
        int          op;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [3:0]  btn;
        logic [15:0] sw;
        int          ncyc;
        logic [31:0] exp;
        int          irq;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [3:0]  buttons_n;
    logic [15:0] switches;
    logic        irq;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[$];
    vec_t v;

    pushbutton_capture_slave #(.DEBOUNCE_CYCLES(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .buttons_n         (buttons_n),
        .switches          (switches),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        avs_read = 1'b1;
        avs_address = a;
        @(posedge clk);
        @(negedge clk);
        avs_read = 1'b0;
        chk({nm, "_vld"}, {31'h0, avs_readdatavalid}, 32'h1);
        chk(nm, avs_readdata, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_write = 1'b1;
        avs_address = a;
        avs_writedata = d;
        @(posedge clk);
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic hold(input logic [3:0] b, input logic [15:0] s, input int n);
        @(negedge clk);
        buttons_n = b;
        switches = s;
        repeat (n) @(posedge clk);
    endtask

    function automatic vec_t mk(int op, logic [1:0] a, logic [31:0] d, logic [3:0] b,
                                logic [15:0] s, int n, logic [31:0] e, int q);
        vec_t r;
        r.op = op; r.addr = a; r.data = d; r.btn = b; r.sw = s;
        r.ncyc = n; r.exp = e; r.irq = q;
        return r;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        avs_address = 2'd0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = 32'h0;
        buttons_n = 4'hF;
        switches = 16'h0000;

        // {op, addr, wdata, buttons_n, switches, cycles, expected readdata, expected irq (-1 = skip)}
        vecs.push_back(mk(OP_RD,   0, 0, 4'hF, 16'h0000, 0, 32'h0, 0));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'h0000, 0, 32'h0, 0));
        vecs.push_back(mk(OP_RD,   2, 0, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   3, 0, 4'hF, 16'h0000, 0, 32'h0, 0));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hB, 16'h0000, 3, 32'h0, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hF, 16'h0000, 8, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   3, 0, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hB, 16'h0000, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hB, 16'h0000, 0, 32'h4, 0));
        vecs.push_back(mk(OP_RD,   0, 0, 4'hB, 16'h0000, 0, 32'h4, -1));
        vecs.push_back(mk(OP_RD,   3, 0, 4'hB, 16'h0000, 0, 32'h1, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hF, 16'h0000, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   0, 0, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'h0000, 0, 32'h4, -1));
        vecs.push_back(mk(OP_WR,   1, 32'h4, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_WR,   2, 32'h4, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   2, 0, 4'hF, 16'h0000, 0, 32'h4, 0));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hB, 16'h0000, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hB, 16'h0000, 0, 32'h4, 1));
        vecs.push_back(mk(OP_WR,   1, 32'h1, 4'hB, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hB, 16'h0000, 2, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hB, 16'h0000, 0, 32'h4, 1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hF, 16'h0000, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   0, 0, 4'hF, 16'h0000, 0, 32'h0, 1));
        vecs.push_back(mk(OP_WR,   1, 32'h4, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'h0000, 0, 32'h0, 0));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'h6, 16'h0000, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'h6, 16'h0000, 0, 32'h9, 0));
        vecs.push_back(mk(OP_RD,   3, 0, 4'h6, 16'h0000, 0, 32'h3, -1));
        vecs.push_back(mk(OP_RD,   0, 0, 4'h6, 16'h0000, 0, 32'h9, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hF, 16'h0000, 10, 32'h0, -1));
        vecs.push_back(mk(OP_WR,   1, 32'h9, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'h0000, 0, 32'h0, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hF, 16'hA5C3, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   0, 0, 4'hF, 16'hA5C3, 0, 32'h000A5C30, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hD, 16'hA5C3, 10, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   0, 0, 4'hD, 16'hA5C3, 0, 32'h000A5C32, -1));
        vecs.push_back(mk(OP_HOLD, 0, 0, 4'hF, 16'hA5C3, 10, 32'h0, -1));
        vecs.push_back(mk(OP_WR,   0, 32'hFFFFFFFF, 4'hF, 16'hA5C3, 0, 32'h0, -1));
        vecs.push_back(mk(OP_WR,   3, 32'hFFFFFFFF, 4'hF, 16'hA5C3, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   3, 0, 4'hF, 16'hA5C3, 0, 32'h4, -1));
        vecs.push_back(mk(OP_RD,   0, 0, 4'hF, 16'hA5C3, 0, 32'h000A5C30, -1));
        vecs.push_back(mk(OP_WR,   2, 32'hFFFFFFF3, 4'hF, 16'hA5C3, 0, 32'h0, -1));
        vecs.push_back(mk(OP_RD,   2, 0, 4'hF, 16'hA5C3, 0, 32'h3, 1));
        vecs.push_back(mk(OP_RW,   2, 32'h5, 4'hF, 16'hA5C3, 0, 32'h3, -1));
        vecs.push_back(mk(OP_RD,   2, 0, 4'hF, 16'hA5C3, 0, 32'h5, 0));
        vecs.push_back(mk(OP_RW,   1, 32'h2, 4'hF, 16'hA5C3, 0, 32'h2, -1));
        vecs.push_back(mk(OP_RD,   1, 0, 4'hF, 16'hA5C3, 0, 32'h0, -1));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", {31'h0, avs_readdatavalid}, 32'h0);
        chk("rst_rdata", avs_readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            buttons_n = v.btn;
            switches = v.sw;
            case (v.op)
                OP_HOLD: repeat (v.ncyc) @(posedge clk);
                OP_WR: begin
                    avs_write = 1'b1;
                    avs_address = v.addr;
                    avs_writedata = v.data;
                    @(posedge clk);
                    @(negedge clk);
                    avs_write = 1'b0;
                end
                default: begin
                    avs_read = 1'b1;
                    avs_address = v.addr;
                    if (v.op == OP_RW) begin
                        avs_write = 1'b1;
                        avs_writedata = v.data;
                    end
                    @(posedge clk);
                    @(negedge clk);
                    avs_read = 1'b0;
                    avs_write = 1'b0;
                    chk($sformatf("vec%0d_vld", i), {31'h0, avs_readdatavalid}, 32'h1);
                    chk($sformatf("vec%0d_rdata", i), avs_readdata, v.exp);
                    if (v.irq >= 0)
                        chk($sformatf("vec%0d_irq", i), {31'h0, irq}, v.irq[31:0]);
                end
            endcase
        end

        // irq drops exactly one cycle after EDGE is cleared
        wr(2'd2, 32'h4);
        hold(4'hB, 16'hA5C3, 10);
        hold(4'hF, 16'hA5C3, 10);
        @(negedge clk);
        chk("irq_set", {31'h0, irq}, 32'h1);
        avs_write = 1'b1;
        avs_address = 2'd1;
        avs_writedata = 32'h4;
        @(posedge clk);
        @(negedge clk);
        avs_write = 1'b0;
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("irq_drop", {31'h0, irq}, 32'h0);

        // press event lands on the same edge as a write-1-to-clear of that bit
        buttons_n = 4'hE;
        repeat (5) @(posedge clk);
        @(negedge clk);
        avs_write = 1'b1;
        avs_address = 2'd1;
        avs_writedata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        avs_write = 1'b0;
        rd(2'd1, 32'h1, "edge_setwins");
        hold(4'hF, 16'hA5C3, 10);
        rd(2'd3, 32'h6, "count_setwins");
        wr(2'd1, 32'h1);

        // back-to-back reads, then idle readdata must be zero
        @(negedge clk);
        avs_read = 1'b1;
        avs_address = 2'd2;
        @(posedge clk);
        @(negedge clk);
        chk("b2b0_vld", {31'h0, avs_readdatavalid}, 32'h1);
        chk("b2b0", avs_readdata, 32'h4);
        avs_address = 2'd3;
        @(posedge clk);
        @(negedge clk);
        chk("b2b1_vld", {31'h0, avs_readdatavalid}, 32'h1);
        chk("b2b1", avs_readdata, 32'h6);
        avs_address = 2'd0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b2_vld", {31'h0, avs_readdatavalid}, 32'h1);
        chk("b2b2", avs_readdata, 32'h000A5C30);
        avs_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_vld", {31'h0, avs_readdatavalid}, 32'h0);
        chk("b2b_idle_rdata", avs_readdata, 32'h0);

        // COUNT wrap from 0xFFFF
        @(negedge clk);
        force dut.r_press_cnt = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.r_press_cnt;
        rd(2'd3, 32'h0000FFFF, "count_preload");
        hold(4'h7, 16'hA5C3, 10);
        hold(4'hF, 16'hA5C3, 10);
        rd(2'd3, 32'h0, "count_wrap");
        rd(2'd1, 32'h8, "edge_btn3");

        // reset mid-debounce and together with a read request
        wr(2'd2, 32'h8);
        hold(4'hF, 16'h0000, 2);
        @(negedge clk);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        buttons_n = 4'hD;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        avs_read = 1'b1;
        avs_address = 2'd3;
        @(posedge clk);
        @(negedge clk);
        avs_read = 1'b0;
        chk("mid_rst_vld", {31'h0, avs_readdatavalid}, 32'h0);
        chk("mid_rst_rdata", avs_readdata, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_vld2", {31'h0, avs_readdatavalid}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        buttons_n = 4'hF;
        rd(2'd0, 32'h0, "post_rst_data");
        rd(2'd1, 32'h0, "post_rst_edge");
        rd(2'd2, 32'h0, "post_rst_mask");
        rd(2'd3, 32'h0, "post_rst_count");
        hold(4'hF, 16'h0000, 10);
        rd(2'd1, 32'h0, "post_rst_noedge");
        rd(2'd3, 32'h0, "post_rst_nocount");
        chk("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
